// File: rtl/term_accumulator_array.sv
// -----------------------------------------------------------------------------
// term_accumulator_array
//
// Purpose:
//   Multi-lane, budget-limited power-of-two term accumulator. Every lane keeps
//   an unsigned positive and an unsigned negative accumulator. Each accepted
//   beat adds (1 << shift) to one of them, chosen by the lane's sign bit. When
//   the job ends, each lane presents the signed result pos - neg. A nonzero
//   term budget limits how many beats are accumulated. Beats that arrive after
//   the budget is used up are still accepted, but they are dropped.
//
// Optional feature:
//   TERM_ACC_SATURATE_EN - when defined, each accumulator clamps at
//   2^ACC_BIT_WIDTH-1 and holds there. When undefined, each accumulator wraps
//   modulo 2^ACC_BIT_WIDTH.
//
// Ports:
//   clk            clock; all logic updates on the rising edge
//   reset          synchronous, active-high reset
//   start          one-cycle job start; sampled only in IDLE
//   term_budget    maximum number of terms per job, captured with start
//                  (0 = unlimited)
//   in_valid       term beat valid
//   in_ready       term beat accepted when in_valid && in_ready
//   in_last        final beat of the job
//   in_en          per-lane term present
//   in_sign        per-lane sign (1 = positive, 0 = negative)
//   in_shift       per-lane exponent; lane i uses
//                  [i*SHIFT_WIDTH +: SHIFT_WIDTH]
//   out_valid      per-lane results valid
//   out_ready      downstream accepts the results
//   out_result     per-lane signed pos - neg, ACC_BIT_WIDTH+1 bits per lane
//   out_truncated  the budget cut the job short
// -----------------------------------------------------------------------------
module term_accumulator_array #(
  parameter int LANES         = 4,
  parameter int ACC_BIT_WIDTH = 16,
  parameter int SHIFT_WIDTH   = 4,
  parameter int BUDGET_WIDTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [BUDGET_WIDTH-1:0]            term_budget,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [LANES-1:0]                   in_en,
  input  logic [LANES-1:0]                   in_sign,
  input  logic [LANES*SHIFT_WIDTH-1:0]       in_shift,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*(ACC_BIT_WIDTH+1)-1:0] out_result,
  output logic                               out_truncated
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SKIP  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BUDGET_WIDTH-1:0] r_cnt;
  logic [BUDGET_WIDTH-1:0] r_budget;
  logic                    r_trunc;
  logic                    w_accept;
  logic                    w_accum_beat;
  logic                    w_budget_hit;
  logic                    w_clear;
  logic                    w_set_trunc;

  // The accept condition is derived from the state directly. This avoids a
  // combinational path through in_ready inside the next-state logic.
  assign w_accept     = in_valid && ((r_state == S_ACCUM) || (r_state == S_SKIP));
  assign w_accum_beat = w_accept && (r_state == S_ACCUM);
  // The budget is reached on the beat that brings the counter up to it.
  assign w_budget_hit = (r_budget != '0) &&
                        (BUDGET_WIDTH'(r_cnt + 1'b1) == r_budget);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_clear      = 1'b0;
    w_set_trunc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (w_accept) begin
          // in_last wins over a budget hit on the same beat.
          if (in_last) begin
            w_state_next = S_OUT;
          end else if (w_budget_hit) begin
            w_state_next = S_SKIP;
            w_set_trunc  = 1'b1;
          end
        end
      end
      S_SKIP: begin
        in_ready = 1'b1;
        if (w_accept && in_last) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_budget <= '0;
      r_trunc  <= 1'b0;
    end else if (w_clear) begin
      r_cnt    <= '0;
      r_budget <= term_budget;
      r_trunc  <= 1'b0;
    end else begin
      if (w_accum_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_set_trunc) begin
        r_trunc <= 1'b1;
      end
    end
  end

  assign out_truncated = r_trunc;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ACC_BIT_WIDTH-1:0] r_pos;
    logic [ACC_BIT_WIDTH-1:0] r_neg;
    logic [SHIFT_WIDTH-1:0]   w_shift;
    logic [ACC_BIT_WIDTH-1:0] w_term;
    logic [ACC_BIT_WIDTH:0]   w_pos_sum;
    logic [ACC_BIT_WIDTH:0]   w_neg_sum;
    logic [ACC_BIT_WIDTH-1:0] w_pos_new;
    logic [ACC_BIT_WIDTH-1:0] w_neg_new;

    assign w_shift = in_shift[gi*SHIFT_WIDTH +: SHIFT_WIDTH];
    // An exponent at or above the accumulator width contributes nothing.
    assign w_term  = (32'(w_shift) >= 32'(ACC_BIT_WIDTH)) ? '0
                   : (ACC_BIT_WIDTH'(1) << w_shift);

    // Each sum has one extra bit so that the carry out shows an overflow.
    assign w_pos_sum = {1'b0, r_pos} + {1'b0, w_term};
    assign w_neg_sum = {1'b0, r_neg} + {1'b0, w_term};

`ifdef TERM_ACC_SATURATE_EN
    assign w_pos_new = w_pos_sum[ACC_BIT_WIDTH] ? '1 : w_pos_sum[ACC_BIT_WIDTH-1:0];
    assign w_neg_new = w_neg_sum[ACC_BIT_WIDTH] ? '1 : w_neg_sum[ACC_BIT_WIDTH-1:0];
`else
    assign w_pos_new = w_pos_sum[ACC_BIT_WIDTH-1:0];
    assign w_neg_new = w_neg_sum[ACC_BIT_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
      if (reset || w_clear) begin
        r_pos <= '0;
        r_neg <= '0;
      end else if (w_accum_beat && in_en[gi]) begin
        if (in_sign[gi]) begin
          r_pos <= w_pos_new;
        end else begin
          r_neg <= w_neg_new;
        end
      end
    end

    // The result reads as zero outside OUT, so partial sums never show.
    assign out_result[gi*(ACC_BIT_WIDTH+1) +: (ACC_BIT_WIDTH+1)] =
      (r_state == S_OUT) ? ({1'b0, r_pos} - {1'b0, r_neg}) : '0;
  end

endmodule

// File: tb/tb_term_accumulator_array.sv
// -----------------------------------------------------------------------------
// tb_term_accumulator_array
//
// Purpose:
//   Self-checking testbench for term_accumulator_array. It runs directed
//   scenarios and randomized jobs. Expected results come from an arithmetic
//   model of pos/neg sums under the term budget. The DUT is built with
//   SHIFT_WIDTH=5, so exponents at and above ACC_BIT_WIDTH can be driven.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_term_accumulator_array;
  localparam int L  = 4;
  localparam int AW = 16;
  localparam int SW = 5;
  localparam int BW = 4;
  localparam int RW = AW + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [BW-1:0]   term_budget;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [L-1:0]    in_en;
  logic [L-1:0]    in_sign;
  logic [L*SW-1:0] in_shift;
  logic            out_valid;
  logic            out_ready;
  logic [L*RW-1:0] out_result;
  logic            out_truncated;

  int n_checks = 0;
  int n_fail   = 0;

  // Beat table for the job that is about to be driven.
  logic [L-1:0]    bq_en    [64];
  logic [L-1:0]    bq_sign  [64];
  logic [L*SW-1:0] bq_shift [64];
  // Expected results for the job.
  logic [RW-1:0]   exp_res  [L];
  logic            exp_trunc;

  always #5 clk = ~clk;

  term_accumulator_array #(
    .LANES(L), .ACC_BIT_WIDTH(AW), .SHIFT_WIDTH(SW), .BUDGET_WIDTH(BW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .term_budget(term_budget),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_en(in_en), .in_sign(in_sign), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_truncated(out_truncated)
  );

  task automatic clear_beats();
    for (int k = 0; k < 64; k++) begin
      bq_en[k] = '0; bq_sign[k] = '0; bq_shift[k] = '0;
    end
    for (int l = 0; l < L; l++) exp_res[l] = '0;
    exp_trunc = 1'b0;
  endtask

  task automatic put_term(input int k, input int lane, input bit sgn, input int sh);
    logic [SW-1:0] s;
    s = SW'(sh);
    bq_en[k][lane]              = 1'b1;
    bq_sign[k][lane]            = sgn;
    bq_shift[k][lane*SW +: SW]  = s;
  endtask

  // Reference model: only the first `used` beats count. Each term is
  // 2^shift, or 0 when the shift is out of range. Each sum is wrapped or
  // clamped after every addition.
  task automatic model_job(input int budget, input int n);
    longint pos, neg, term;
    int used;
    bit cut;
    cut  = (budget != 0) && (n > budget);
    used = cut ? budget : n;
    exp_trunc = cut;
    for (int l = 0; l < L; l++) begin
      pos = 0; neg = 0;
      for (int k = 0; k < used; k++) begin
        if (bq_en[k][l]) begin
          term = (int'(bq_shift[k][l*SW +: SW]) < AW) ? (64'd1 << bq_shift[k][l*SW +: SW]) : 0;
          if (bq_sign[k][l]) pos = pos + term; else neg = neg + term;
`ifdef TERM_ACC_SATURATE_EN
          if (pos > 65535) pos = 65535;
          if (neg > 65535) neg = 65535;
`else
          pos = pos % 65536;
          neg = neg % 65536;
`endif
        end
      end
      exp_res[l] = RW'(pos - neg);
    end
  endtask

  // Drives one job from IDLE. Holds out_ready low for `hold` cycles while
  // OUT is active. When pulse_start is set, start is asserted during the
  // stall and during the handshake cycle.
  task automatic do_job(input string name, input int budget, input int n,
                        input int hold, input bit pulse_start);
    int k, guard;
    logic [RW-1:0] got;
    start = 1'b1; term_budget = BW'(budget);
    @(negedge clk);
    start = 1'b0; term_budget = BW'($urandom);
    k = 0; guard = 0;
    while (k < n && guard < 500) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        in_en = bq_en[k]; in_sign = bq_sign[k]; in_shift = bq_shift[k];
        in_last = (k == n - 1);
      end else begin
        in_en = L'($urandom); in_sign = L'($urandom);
        in_shift = (L*SW)'($urandom); in_last = 1'($urandom);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready_during_beats: got %b want 1", name, in_ready);
      end
      if (in_valid && in_ready) k++;
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL %s beat_timeout: accepted %0d want %0d", name, k, n);
    end
    in_valid = 1'b0; in_last = 1'b0; in_en = '0;
    // This is the first cycle after the last beat, so OUT must be active now.
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid_latency: got %b want 1", name, out_valid);
    end
    n_checks++;
    if (out_truncated !== exp_trunc) begin
      n_fail++;
      $display("FAIL %s out_truncated: got %b want %b", name, out_truncated, exp_trunc);
    end
    for (int l = 0; l < L; l++) begin
      got = out_result[l*RW +: RW];
      n_checks++;
      if (got !== exp_res[l]) begin
        n_fail++;
        $display("FAIL %s lane%0d_result: got %h want %h", name, l, got, exp_res[l]);
      end
    end
    for (int c = 0; c < hold; c++) begin
      out_ready = 1'b0; start = pulse_start;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall_handshake: got valid=%b ready=%b want valid=1 ready=0",
                 name, out_valid, in_ready);
      end
      for (int l = 0; l < L; l++) begin
        got = out_result[l*RW +: RW];
        n_checks++;
        if (got !== exp_res[l]) begin
          n_fail++;
          $display("FAIL %s stall_lane%0d_result: got %h want %h", name, l, got, exp_res[l]);
        end
      end
    end
    out_ready = 1'b1; start = pulse_start;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: got valid=%b ready=%b want 0/0", name, out_valid, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_ignored: got in_ready=%b want 0", name, in_ready);
    end
    $display("job %s budget=%0d beats=%0d hold=%0d done", name, budget, n, hold);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; term_budget = '1; in_valid = 1'b1; in_last = 1'b0;
    in_en = '1; in_sign = '1; in_shift = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_en = '0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_truncated !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%b valid=%b trunc=%b want 0/0/0",
               in_ready, out_valid, out_truncated);
    end
    n_checks++;
    if (out_result !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", out_result);
    end
    $display("reset check done");
  endtask

  task automatic test_basic_sum();
    clear_beats();
    put_term(0, 0, 1'b1, 2); put_term(1, 0, 1'b1, 0); put_term(2, 0, 1'b0, 1);
    exp_res[0] = 17'd3;
    do_job("basic_sum", 0, 3, 0, 1'b0);
  endtask

  task automatic test_budget_trunc();
    clear_beats();
    for (int k = 0; k < 5; k++) put_term(k, 1, 1'b1, 3);
    exp_res[1] = 17'd16; exp_trunc = 1'b1;
    do_job("budget_trunc", 2, 5, 0, 1'b0);
    clear_beats();
    for (int k = 0; k < 4; k++) put_term(k, 0, 1'b1, 1);
    exp_res[0] = 17'd2; exp_trunc = 1'b1;
    do_job("budget_one", 1, 4, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    clear_beats();
    put_term(0, 0, 1'b1, 5); put_term(0, 2, 1'b0, 4);
    exp_res[0] = 17'd32; exp_res[2] = 17'h1FFF0;
    do_job("backpressure", 0, 1, 4, 1'b1);
  endtask

  task automatic test_boundaries();
    clear_beats();
    put_term(0, 2, 1'b1, 15); put_term(1, 2, 1'b1, 16); put_term(2, 2, 1'b1, 31);
    exp_res[2] = 17'h08000;
    do_job("shift_bounds", 0, 3, 0, 1'b0);
    clear_beats();
    for (int k = 0; k < 3; k++) put_term(k, 0, 1'b1, 0);
    exp_res[0] = 17'd3; exp_trunc = 1'b0;
    do_job("budget_on_last", 3, 3, 0, 1'b0);
  endtask

  task automatic test_overflow();
    clear_beats();
    for (int k = 0; k < 3; k++) put_term(k, 3, 1'b1, 15);
`ifdef TERM_ACC_SATURATE_EN
    exp_res[3] = 17'd65535;
`else
    exp_res[3] = 17'd32768;
`endif
    do_job("overflow", 0, 3, 0, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; term_budget = '0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_en = 4'b0001; in_sign = 4'b0001;
    in_shift = (L*SW)'(10); in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_en = '0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_truncated !== 1'b0 || out_result !== '0) begin
      n_fail++;
      $display("FAIL midjob_reset_state: got ready=%b valid=%b trunc=%b res=%h want all 0",
               in_ready, out_valid, out_truncated, out_result);
    end
    clear_beats();
    put_term(0, 0, 1'b1, 0);
    exp_res[0] = 17'd1;
    do_job("after_reset", 0, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int n, budget;
    for (int j = 0; j < 25; j++) begin
      clear_beats();
      n = $urandom_range(1, 8);
      budget = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        for (int l = 0; l < L; l++) begin
          if ($urandom_range(0, 3) != 0) put_term(k, l, 1'($urandom), $urandom_range(0, 17));
        end
      end
      model_job(budget, n);
      do_job($sformatf("random%0d", j), budget, n, $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_budget_trunc();
    test_backpressure();
    test_boundaries();
    test_overflow();
    test_reset_mid_job();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
